gpo_pad_seq: RTL and testbench
==============================

Name: gpo_pad_seq

Overview:
- Core-side output sequencer for a general-purpose pad; the transmit counterpart of the GPI input receiver.
- Drives the pad's data-out, output-enable and drive-strength pins.
- Enforces glitch-free sequencing: drive strength settles before OE rises, and OE is low for a turnaround window before any reconfiguration.
- Supports push-pull and open-drain modes. Reads back the pad receiver output and raises a sticky contention flag.

Parameters:
- DS_W, 2, width of the drive-strength code.
- SETTLE_CYC, 4, cycles between applying the config and asserting OE; must be >= 1.
- TURN_CYC, 2, cycles OE is held low before reconfiguring or going idle; must be >= 1.
- CHK_DLY, 4, cycles of stable pad output before a readback compare; must be >= 3 (covers the 2-flop sync plus pad delay).

Ports:
- clk_i  in  1  block clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  request to drive the pad
- od_i  in  1  1 = open-drain mode, 0 = push-pull
- ds_i  in  DS_W  requested drive strength
- do_i  in  1  data to drive
- err_clr_i  in  1  clears err_o
- pad_di_i  in  1  pad receiver output (asynchronous)
- pad_do_o  out  1  pad data-out
- pad_oe_o  out  1  pad output enable
- pad_ds_o  out  DS_W  pad drive strength
- pad_ie_o  out  1  pad input enable (for readback)
- busy_o  out  1  high in CFG or TURN
- active_o  out  1  high in DRIVE
- err_o  out  1  sticky contention flag

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, latched od/ds = 0. Assertion mid-operation drops pad_oe_o immediately, without waiting for a clock.
- Output timing: all outputs are registered and update on the same edge as the state transition.
- States: IDLE, CFG, DRIVE, TURN.
- IDLE:
  - pad_oe_o=0, pad_do_o=0, pad_ie_o=0.
  - en_i=1 at edge k: latch od_i and ds_i; pad_ds_o=ds_i; load the counter; go to CFG at k.
- CFG:
  - pad_oe_o=0, pad_ie_o=1. Stays SETTLE_CYC cycles.
  - en_i=0 → IDLE next edge; OE is never asserted.
  - ds_i or od_i differs from the latched value → relatch and restart the count.
  - Count done → DRIVE at edge k+SETTLE_CYC; pad_oe_o rises on that edge.
- DRIVE outputs:
  - Push-pull: pad_oe_o=1, pad_do_o = do_i registered (1-cycle latency).
  - Open-drain: pad_do_o=0, pad_oe_o = ~do_i registered (1-cycle latency).
- DRIVE exit: en_i=0, or ds_i/od_i differs from the latched value, sampled at edge m → TURN at m, with pad_oe_o=0 from m.
- TURN:
  - pad_oe_o=0, pad_ie_o=1. Stays TURN_CYC cycles.
  - At the end: en_i=1 → CFG with freshly latched ds_i/od_i; otherwise → IDLE.
  - Requests during TURN never shorten the window.
- Readback path:
  - pad_di_i passes through a 2-flop synchronizer.
  - A stability counter resets on any change of pad_do_o or pad_oe_o, and counts only in DRIVE.
  - When the counter reaches CHK_DLY with pad_oe_o=1 and the synced DI != pad_do_o: set err_o.
  - No compare while pad_oe_o=0 (open-drain released level is externally defined).
  - One compare per stable period; the counter saturates.
- err_o:
  - Sticky; cleared by err_clr_i.
  - Set and clear in the same cycle → set wins.
  - Unaffected by state changes; only reset clears it otherwise.
- Status: busy_o is registered from the state. active_o = (state == DRIVE).

Decomposition:
- Package gpo_pad_pkg holds:
  - the state enum (IDLE, CFG, DRIVE, TURN);
  - default parameter constants;
  - a DS code typedef sized by DS_W.
- Sub-module pad_sync2: generic 2-flop synchronizer with async active-low reset to 0, used for pad_di_i.
- Everything else lives in gpo_pad_seq.

Test Plan:
- Push-pull enable sequence: reset, ds_i=2, od_i=0, do_i=1, en_i=1 at edge 1 → pad_ds_o=2 after edge 1; pad_oe_o=1 and pad_do_o=1 after edge 5; busy_o=1 for edges 1–4.
- Disable: en_i=0 at edge 20 in DRIVE → pad_oe_o=0 after edge 20; busy_o=1 for 2 cycles; IDLE and pad_ie_o=0 after edge 22.
- Open-drain toggle: od_i=1, do_i toggles 1,0,1 in DRIVE → pad_do_o stays 0; pad_oe_o follows 0,1,0 one cycle late. pad_di_i tied to ~pad_oe_o → err_o stays 0.
- Contention: push-pull drive 1 with pad_di_i forced 0 → err_o=1 exactly CHK_DLY=4 cycles after the last output change. Hold err_clr_i=1 while contention persists past the next compare → err_o stays 1 (set wins).
- Reconfigure: change ds_i 2→3 in DRIVE → OE low for 2 cycles, then 4 CFG cycles with pad_ds_o=3, then OE high again; OE is never high while pad_ds_o changes.
- Async reset in DRIVE: pulse rst_ni low mid-cycle → pad_oe_o, pad_do_o, err_o and busy_o go to 0 without a clock edge; the block restarts from IDLE.

Source files
------------

// File: rtl/gpo_pad_pkg.sv
// Shared types and default parameters for the general-purpose pad output sequencer.
// The state enum is also used by the bench to observe the FSM through its debug port.
package gpo_pad_pkg;

    localparam int DS_W_DEF       = 2;
    localparam int SETTLE_CYC_DEF = 4;
    localparam int TURN_CYC_DEF   = 2;
    localparam int CHK_DLY_DEF    = 4;

    localparam int DS_W = DS_W_DEF;
    typedef logic [DS_W-1:0] ds_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CFG   = 2'd1,
        ST_DRIVE = 2'd2,
        ST_TURN  = 2'd3
    } pad_state_e;

endpackage

// File: rtl/pad_sync2.sv
// Generic two-flop synchronizer for asynchronous inputs.
// It resets to zero, asynchronously and active-low.
module pad_sync2 #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta <= '0;
            q_o  <= '0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/gpo_pad_seq.sv
// Core-side pad output sequencer: settles drive strength before OE, enforces an OE-low turnaround,
// supports push-pull / open-drain, and flags readback contention. en_i is a level request, not a
// handshake: holding it keeps the pad driven, dropping it starts the turnaround.
module gpo_pad_seq
    import gpo_pad_pkg::*;
#(
    parameter int DS_W       = DS_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int TURN_CYC   = TURN_CYC_DEF,
    parameter int CHK_DLY    = CHK_DLY_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            od_i,
    input  logic [DS_W-1:0] ds_i,
    input  logic            do_i,
    input  logic            err_clr_i,
    input  logic            pad_di_i,
    output logic            pad_do_o,
    output logic            pad_oe_o,
    output logic [DS_W-1:0] pad_ds_o,
    output logic            pad_ie_o,
    output logic            busy_o,
    output logic            active_o,
    output logic            err_o,
    output pad_state_e      dbg_state_o
);

    localparam int CNT_MAX = (SETTLE_CYC > TURN_CYC) ? SETTLE_CYC : TURN_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STAB_W  = $clog2(CHK_DLY + 1);

    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  TURN_LD   = CNT_W'(TURN_CYC - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(CHK_DLY);
    localparam logic [STAB_W-1:0] STAB_CMP  = STAB_W'(CHK_DLY - 1);

    pad_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             lat_od;
    logic [DS_W-1:0]  lat_ds;
    logic             cfg_chg;

    assign cfg_chg     = (ds_i != lat_ds) || (od_i != lat_od);
    assign dbg_state_o = state;

    // Single FSM; every pad pin and status bit is updated on the same edge as the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            lat_od   <= 1'b0;
            lat_ds   <= '0;
            pad_do_o <= 1'b0;
            pad_oe_o <= 1'b0;
            pad_ds_o <= '0;
            pad_ie_o <= 1'b0;
            busy_o   <= 1'b0;
            active_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en_i) begin
                        state    <= ST_CFG;
                        lat_od   <= od_i;
                        lat_ds   <= ds_i;
                        pad_ds_o <= ds_i;
                        cnt      <= SETTLE_LD;
                        pad_ie_o <= 1'b1;
                        busy_o   <= 1'b1;
                    end
                end
                ST_CFG: begin
                    if (!en_i) begin
                        state    <= ST_IDLE;
                        pad_ie_o <= 1'b0;
                        busy_o   <= 1'b0;
                    end else if (cfg_chg) begin
                        lat_od   <= od_i;
                        lat_ds   <= ds_i;
                        pad_ds_o <= ds_i;
                        cnt      <= SETTLE_LD;
                    end else if (cnt == '0) begin
                        state    <= ST_DRIVE;
                        busy_o   <= 1'b0;
                        active_o <= 1'b1;
                        pad_oe_o <= lat_od ? ~do_i : 1'b1;
                        pad_do_o <= lat_od ? 1'b0 : do_i;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (!en_i || cfg_chg) begin
                        state    <= ST_TURN;
                        cnt      <= TURN_LD;
                        pad_oe_o <= 1'b0;
                        pad_do_o <= 1'b0;
                        busy_o   <= 1'b1;
                        active_o <= 1'b0;
                    end else begin
                        pad_oe_o <= lat_od ? ~do_i : 1'b1;
                        pad_do_o <= lat_od ? 1'b0 : do_i;
                    end
                end
                ST_TURN: begin
                    // The window always runs to completion; requests are only looked at when it ends.
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (en_i) begin
                        state    <= ST_CFG;
                        lat_od   <= od_i;
                        lat_ds   <= ds_i;
                        pad_ds_o <= ds_i;
                        cnt      <= SETTLE_LD;
                    end else begin
                        state    <= ST_IDLE;
                        pad_ie_o <= 1'b0;
                        busy_o   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic              di_s;
    logic              prev_do;
    logic              prev_oe;
    logic [STAB_W-1:0] stab_cnt;
    logic              out_chg;
    logic              cmp_hit;

    pad_sync2 #(.W(1)) u_di_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (pad_di_i),
        .q_o   (di_s)
    );

    // stab_cnt = edges the registered pad outputs have held their value while driving.
    assign out_chg = (pad_do_o != prev_do) || (pad_oe_o != prev_oe);
    assign cmp_hit = (state == ST_DRIVE) && !out_chg && (stab_cnt == STAB_CMP) &&
                     pad_oe_o && (di_s != pad_do_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_do  <= 1'b0;
            prev_oe  <= 1'b0;
            stab_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            prev_do <= pad_do_o;
            prev_oe <= pad_oe_o;
            if (state != ST_DRIVE) begin
                stab_cnt <= '0;
            end else if (out_chg) begin
                stab_cnt <= STAB_W'(1);
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + STAB_W'(1);
            end
            if (cmp_hit) begin
                err_o <= 1'b1;
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpo_pad_seq.sv
// Self-checking bench for gpo_pad_seq: directed per-edge vectors feed an expected queue,
// a monitor pops and compares each entry just after the edge it belongs to.
module tb_gpo_pad_seq;
    import gpo_pad_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       en_i = 1'b0;
    logic       od_i = 1'b0;
    ds_code_t   ds_i = '0;
    logic       do_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic       pad_di_i;
    logic       pad_do_o, pad_oe_o, pad_ie_o, busy_o, active_o, err_o;
    ds_code_t   pad_ds_o;
    pad_state_e dbg_state;

    // Pad model: a healthy pad reads back what it drives, pull-up when released.
    logic frc_en = 1'b0;
    logic frc_val = 1'b0;
    assign pad_di_i = frc_en ? frc_val : (pad_oe_o ? pad_do_o : 1'b1);

    always #5 clk = ~clk;

    gpo_pad_seq dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .od_i       (od_i),
        .ds_i       (ds_i),
        .do_i       (do_i),
        .err_clr_i  (err_clr_i),
        .pad_di_i   (pad_di_i),
        .pad_do_o   (pad_do_o),
        .pad_oe_o   (pad_oe_o),
        .pad_ds_o   (pad_ds_o),
        .pad_ie_o   (pad_ie_o),
        .busy_o     (busy_o),
        .active_o   (active_o),
        .err_o      (err_o),
        .dbg_state_o(dbg_state)
    );

    // Observation vector: {do, oe, ds[1:0], ie, busy, active, err}
    logic [7:0] obs;
    assign obs = {pad_do_o, pad_oe_o, pad_ds_o, pad_ie_o, busy_o, active_o, err_o};

    localparam logic [7:0] ALL   = 8'hFF;
    localparam logic [7:0] NO_DS = 8'hCF;

    logic [7:0] exp_q[$];
    logic [7:0] msk_q[$];
    logic [7:0] act_q[$];
    bit         use_act_q[$];
    int         tag_q[$];
    string      name_q[$];

    int edge_cnt = 0;
    int n_checks = 0;
    int n_errors = 0;
    bit done = 1'b0;

    function automatic logic [7:0] snap(input logic d, input logic o, input logic [1:0] s,
                                        input logic ie, input logic b, input logic a,
                                        input logic e);
        return {d, o, s, ie, b, a, e};
    endfunction

    function automatic logic [7:0] cfg_v(input logic [1:0] s, input logic e);
        return snap(1'b0, 1'b0, s, 1'b1, 1'b1, 1'b0, e);
    endfunction

    function automatic logic [7:0] drv_v(input logic d, input logic o, input logic [1:0] s,
                                         input logic e);
        return snap(d, o, s, 1'b1, 1'b0, 1'b1, e);
    endfunction

    function automatic logic [7:0] idle_v(input logic e);
        return snap(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, e);
    endfunction

    // Driver: apply inputs for the coming edge, queue what must be seen after it.
    task automatic step(input logic en, input logic od, input logic [1:0] ds, input logic d,
                        input logic clr, input logic [7:0] e, input logic [7:0] m,
                        input string nm);
        en_i = en; od_i = od; ds_i = ds; do_i = d; err_clr_i = clr;
        tag_q.push_back(edge_cnt + 1);
        exp_q.push_back(e);
        msk_q.push_back(m);
        act_q.push_back(8'h00);
        use_act_q.push_back(1'b0);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    // Queue a value captured off-edge by the driver; the monitor still does the compare.
    task automatic push_captured(input logic [7:0] a, input logic [7:0] e, input string nm);
        tag_q.push_back(edge_cnt + 1);
        exp_q.push_back(e);
        msk_q.push_back(ALL);
        act_q.push_back(a);
        use_act_q.push_back(1'b1);
        name_q.push_back(nm);
    endtask

    // Monitor / scoreboard
    initial begin
        int drain;
        drain = 0;
        forever begin
            @(posedge clk);
            #1;
            edge_cnt++;
            while (tag_q.size() > 0 && tag_q[0] <= edge_cnt) begin
                int         t;
                logic [7:0] e, m, a, got;
                bit         ua;
                string      nm;
                t = tag_q.pop_front();
                e = exp_q.pop_front();
                m = msk_q.pop_front();
                a = act_q.pop_front();
                ua = use_act_q.pop_front();
                nm = name_q.pop_front();
                got = ua ? a : obs;
                n_checks++;
                if ((got & m) !== (e & m)) begin
                    n_errors++;
                    $display("FAIL %s edge %0d: got %b required %b (mask %b) [do oe ds ie busy act err]",
                             nm, t, got, e, m);
                end
            end
            if (done) begin
                drain++;
                if (tag_q.size() == 0 || drain > 10) begin
                    if (tag_q.size() > 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL drain: %0d entries left, required 0", tag_q.size());
                    end
                    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
                    $finish;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, required finish by 200000");
        $fatal(1);
    end

    initial begin
        logic [7:0] e;
        logic [1:0] ds_v;
        logic       d, o, en, clr, er;

        @(negedge clk);
        // Reset state
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, ALL, "reset");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, ALL, "reset");
        rst_ni = 1'b1;
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, ALL, "post_reset");

        // Push-pull enable, hold, disable
        for (int i = 1; i <= 22; i++) begin
            if (i < 5)       e = cfg_v(2'd2, 1'b0);
            else if (i < 20) e = drv_v(1'b1, 1'b1, 2'd2, 1'b0);
            else if (i < 22) e = snap(1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
            else             e = idle_v(1'b0);
            step(i < 20, 1'b0, 2'd2, 1'b1, 1'b0, e, (i == 22) ? NO_DS : ALL, "pp_seq");
        end
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, idle_v(1'b0), NO_DS, "idle_hold");

        // Open-drain: do_i 1,0,1 then held low; healthy pad reads ~OE
        for (int i = 1; i <= 16; i++) begin
            d = (i == 5 || i == 7) ? 1'b1 : ((i >= 6) ? 1'b0 : 1'b1);
            o = (i == 6 || i >= 8);
            if (i < 5)       e = cfg_v(2'd1, 1'b0);
            else if (i < 14) e = drv_v(1'b0, o, 2'd1, 1'b0);
            else if (i < 16) e = snap(1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
            else             e = idle_v(1'b0);
            step(i < 14, 1'b1, 2'd1, d, 1'b0, e, (i == 16) ? NO_DS : ALL, "od_seq");
        end

        // Contention: pad stuck low while driving 1; set beats a coincident clear
        frc_en = 1'b1;
        frc_val = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            en  = (i < 22);
            d   = (i == 12) ? 1'b0 : 1'b1;
            clr = (i == 17 || i == 18);
            er  = (i >= 9 && i <= 17);
            if (i < 5)       e = cfg_v(2'd2, 1'b0);
            else if (i < 22) e = drv_v(d, 1'b1, 2'd2, er);
            else if (i < 24) e = snap(1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
            else             e = idle_v(1'b0);
            step(en, 1'b0, 2'd2, 1'b1 & d, clr, e, (i == 24) ? NO_DS : ALL, "contention");
        end
        frc_en = 1'b0;

        // Reconfigure ds 2->3 while driving
        for (int i = 1; i <= 18; i++) begin
            ds_v = (i >= 8) ? 2'd3 : 2'd2;
            if (i < 5)       e = cfg_v(2'd2, 1'b0);
            else if (i < 8)  e = drv_v(1'b1, 1'b1, 2'd2, 1'b0);
            else if (i < 10) e = snap(1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
            else if (i < 14) e = cfg_v(2'd3, 1'b0);
            else if (i < 16) e = drv_v(1'b1, 1'b1, 2'd3, 1'b0);
            else if (i < 18) e = snap(1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
            else             e = idle_v(1'b0);
            step(i < 16, 1'b0, ds_v, 1'b1, 1'b0, e, (i == 18) ? NO_DS : ALL, "reconfig");
        end

        // Change during CFG restarts settle; dropping en in CFG never raises OE
        for (int i = 1; i <= 12; i++) begin
            ds_v = (i >= 3) ? 2'd2 : 2'd1;
            if (i < 3)       e = cfg_v(2'd1, 1'b0);
            else if (i < 7)  e = cfg_v(2'd2, 1'b0);
            else if (i < 8)  e = drv_v(1'b1, 1'b1, 2'd2, 1'b0);
            else if (i < 10) e = snap(1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
            else if (i == 11) e = cfg_v(2'd2, 1'b0);
            else             e = idle_v(1'b0);
            step(i < 8 || i == 11, 1'b0, ds_v, 1'b1, 1'b0, e,
                 (i == 10 || i == 12) ? NO_DS : ALL, "cfg_restart");
        end

        // Async reset while driving with err set
        frc_en = 1'b1;
        frc_val = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i < 5) e = cfg_v(2'd2, 1'b0);
            else       e = drv_v(1'b1, 1'b1, 2'd2, i >= 9);
            step(1'b1, 1'b0, 2'd2, 1'b1, 1'b0, e, ALL, "pre_async");
        end
        #2;
        rst_ni = 1'b0;
        #1;
        push_captured(obs, 8'h00, "async_rst_outputs");
        push_captured({6'd0, dbg_state}, {6'd0, ST_IDLE}, "async_rst_state");
        @(negedge clk);
        frc_en = 1'b0;
        en_i = 1'b0;
        rst_ni = 1'b1;
        step(1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 8'h00, ALL, "after_rst");
        for (int i = 1; i <= 9; i++) begin
            if (i < 5)      e = cfg_v(2'd2, 1'b0);
            else if (i < 7) e = drv_v(1'b1, 1'b1, 2'd2, 1'b0);
            else if (i < 9) e = snap(1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
            else            e = idle_v(1'b0);
            step(i < 7, 1'b0, 2'd2, 1'b1, 1'b0, e, (i == 9) ? NO_DS : ALL, "restart");
        end

        done = 1'b1;
    end

endmodule
